// File: rtl/pipe_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard logic.
//   FWD_* : operand-mux select encodings (11 is never driven)
//   REG_AW: register-address width
//   stage_t: destination info carried by a shadow pipeline stage
package pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB write-back data

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } stage_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX operand.
//   src        : source register read by the instruction in EX
//   used       : operand is actually read (and EX holds a real instruction)
//   mem        : shadow MEM-stage entry
//   wb_valid, wb_dest, wb_regwrite : shadow WB-stage entry
//   sel        : 2-bit mux select (FWD_REG / FWD_MEM / FWD_WB)
// Purely combinational.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  stage_t            mem,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  logic nonzero;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    nonzero = (src != '0);
    // A load sitting in MEM has no value on the EX/MEM bus yet, so it cannot
    // forward from there; the WB entry is still allowed to match.
    mem_hit = used & nonzero & mem.valid & mem.regwrite & ~mem.memread &
              (mem.dest == src);
    wb_hit  = used & nonzero & wb_valid & wb_regwrite & (wb_dest == src);
    // The youngest producer (MEM) wins over WB.
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
    else             sel = FWD_REG;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage MIPS core.
// Keeps a shadow EX/MEM/WB pipeline of destination info and drives the
// selects of the two EX operand muxes, plus a one-cycle load-use stall.
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_valid .. id_memread: decoded fields of the instruction in ID
//   flush                 : taken branch/jump in EX, kills the ID instruction
//   fwd_a_sel, fwd_b_sel  : EX operand A (rs) / B (rt) mux selects
//   stall                 : hold PC and IF/ID, bubble into EX
//   stall_count           : saturating count of stall cycles since reset
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  // Shadow EX stage: destination info plus the sources it reads.
  stage_t            ex_q;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_uses_rt;

  // Shadow MEM and WB stages.
  stage_t            mem_q;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_regwrite;

  logic load_in_ex;
  logic bubble;

  always_comb begin
    load_in_ex = ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.dest != '0);
    // flush wins over the stall: the dependent instruction is being killed.
    stall  = id_valid & ~flush & load_in_ex &
             ((ex_q.dest == id_rs) | (id_uses_rt & (ex_q.dest == id_rt)));
    bubble = flush | stall | ~id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_uses_rt  <= 1'b0;
      mem_q       <= '0;
      wb_valid    <= 1'b0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
      stall_count <= '0;
    end else begin
      wb_valid    <= mem_q.valid;
      wb_dest     <= mem_q.dest;
      wb_regwrite <= mem_q.regwrite;
      mem_q       <= ex_q;
      if (bubble) begin
        ex_q       <= '0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_uses_rt <= 1'b0;
      end else begin
        ex_q       <= '{valid: 1'b1, dest: id_dest, regwrite: id_regwrite,
                        memread: id_memread};
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_uses_rt <= id_uses_rt;
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  fwd_select u_sel_a (
    .src         (ex_rs),
    .used        (ex_q.valid),
    .mem         (mem_q),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_regwrite (wb_regwrite),
    .sel         (fwd_a_sel)
  );

  fwd_select u_sel_b (
    .src         (ex_rt),
    .used        (ex_q.valid & ex_uses_rt),
    .mem         (mem_q),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_regwrite (wb_regwrite),
    .sel         (fwd_b_sel)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// checked against an instruction-level model of the pipeline. A second
// instance with a narrow counter exercises stall_count saturation.
module tb_fwd_hazard_unit;

  localparam int AW  = 5;
  localparam int CW  = 16;
  localparam int SCW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          id_valid, id_uses_rt, id_regwrite, id_memread, flush;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic [1:0]    fwd_a_sel, fwd_b_sel, sat_a, sat_b;
  logic          stall, sat_stall;
  logic [CW-1:0] stall_count;
  logic [SCW-1:0] sat_count;

  fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count)
  );

  fwd_hazard_unit #(.REG_AW(AW), .CNT_W(SCW)) sat_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a_sel(sat_a), .fwd_b_sel(sat_b), .stall(sat_stall),
    .stall_count(sat_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic          valid;
    logic [AW-1:0] rs, rt;
    logic          uses_rt;
    logic [AW-1:0] dest;
    logic          rw, mr;
  } ins_t;

  ins_t          m_pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int            model_cnt;
  logic [1:0]    exp_a, exp_b;
  logic          exp_stall;
  logic [CW-1:0] exp_cnt;
  logic [SCW-1:0] exp_sat;

  // Search older instructions, youngest first, for the one producing r.
  function automatic logic [1:0] model_sel(input logic [AW-1:0] r, input logic used);
    if (!used || r == 0) return 2'b00;
    for (int i = 1; i < 3; i++) begin
      if (m_pipe[i].valid && m_pipe[i].rw && m_pipe[i].dest == r) begin
        if (i == 1 && m_pipe[i].mr) continue;  // load data not on EX/MEM yet
        return (i == 1) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic void model_eval();
    ins_t ex;
    ex = m_pipe[0];
    exp_a = model_sel(ex.rs, ex.valid);
    exp_b = model_sel(ex.rt, ex.valid && ex.uses_rt);
    exp_stall = id_valid && !flush && ex.valid && ex.mr && ex.rw && ex.dest != 0 &&
                (ex.dest == id_rs || (id_uses_rt && ex.dest == id_rt));
    exp_cnt = (model_cnt > 65535) ? 16'hFFFF : 16'(model_cnt);
    exp_sat = (model_cnt > 63) ? 6'd63 : 6'(model_cnt);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{default: 0};
    model_cnt = 0;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive the ID instruction (called just after a falling edge), then settle.
  task automatic issue(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urt, input logic [AW-1:0] dest,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_dest = dest; id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    model_eval();
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; the model retires instructions the same way a
  // pipeline does: everything moves one stage, ID enters EX unless killed.
  task automatic tick();
    @(posedge clk);
    if (exp_stall) model_cnt++;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    if (flush || exp_stall || !id_valid) m_pipe[0] = '{default: 0};
    else m_pipe[0] = '{valid: 1'b1, rs: id_rs, rt: id_rt, uses_rt: id_uses_rt,
                       dest: id_dest, rw: id_regwrite, mr: id_memread};
    @(negedge clk);
    #1;
    model_eval();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_dest = 0; id_regwrite = 0; id_memread = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL reset_a: got %b want 00", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL reset_b: got %b want 00", fwd_b_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ex_mem_forward();
    issue(1, 1, 2, 1, 3, 1, 0, 0); tick();   // add $3,$1,$2
    issue(1, 3, 5, 1, 4, 1, 0, 0); tick();   // sub $4,$3,$5
    nop();
    n_cmp++; if (fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL exmem_a: got %b want 01", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL exmem_b: got %b want 00", fwd_b_sel); end
    tick();
  endtask

  task automatic test_wb_forward_priority();
    issue(1, 1, 2, 1, 3, 1, 0, 0); tick();   // add $3
    nop(); tick();
    issue(1, 3, 3, 1, 6, 1, 0, 0); tick();   // or $6,$3,$3
    nop();
    n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL memwb_a: got %b want 10", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL memwb_b: got %b want 10", fwd_b_sel); end
    tick();
    issue(1, 1, 2, 1, 3, 1, 0, 0); tick();   // add $3
    issue(1, 4, 5, 1, 3, 1, 0, 0); tick();   // add $3
    issue(1, 3, 0, 1, 7, 1, 0, 0); tick();   // and $7,$3,$0
    nop();
    n_cmp++; if (fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL prio_a: got %b want 01", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL prio_b: got %b want 00", fwd_b_sel); end
    tick();
  endtask

  task automatic test_load_use();
    issue(1, 1, 8, 0, 8, 1, 1, 0); tick();   // lw $8,0($1)
    issue(1, 8, 2, 1, 9, 1, 0, 0);           // add $9,$8,$2
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall1: got %b want 1", stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL lu_cnt0: got %0d want 0", stall_count); end
    tick();
    issue(1, 8, 2, 1, 9, 1, 0, 0);           // held add; EX is a bubble
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall2: got %b want 0", stall); end
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL lu_cnt1: got %0d want 1", stall_count); end
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL lu_bubble_a: got %b want 00", fwd_a_sel); end
    tick();
    nop();
    n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL lu_fwd_b: got %b want 00", fwd_b_sel); end
    tick();
  endtask

  task automatic test_zero_and_uses_rt();
    issue(1, 1, 0, 0, 0, 1, 0, 0); tick();   // addi $0,$1,4
    issue(1, 0, 0, 1, 2, 1, 0, 0); tick();   // add $2,$0,$0
    nop();
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL zero_a: got %b want 00", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL zero_b: got %b want 00", fwd_b_sel); end
    tick();
    issue(1, 1, 0, 0, 0, 1, 1, 0); tick();   // lw $0
    issue(1, 0, 0, 1, 2, 1, 0, 0);           // add $2,$0,$0
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", stall); end
    tick();
    issue(1, 1, 5, 0, 5, 1, 1, 0); tick();   // lw $5
    issue(1, 1, 5, 0, 6, 1, 0, 0);           // addi $6,$1,1 (rt field 5)
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nort_stall: got %b want 0", stall); end
    tick();
    issue(1, 1, 2, 1, 7, 1, 0, 0); tick();   // add $7,$1,$2
    issue(1, 1, 7, 0, 6, 1, 0, 0); tick();   // addi $6,$1,imm (rt field 7)
    nop();
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL nort_b: got %b want 00", fwd_b_sel); end
    tick();
  endtask

  task automatic test_flush_vs_stall();
    issue(1, 1, 8, 0, 8, 1, 1, 0); tick();   // lw $8
    issue(1, 8, 10, 0, 10, 1, 1, 1);         // lw $10,0($8) with flush
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    n_cmp++; if (stall_count !== 16'd1) begin n_bad++; $display("FAIL flush_cnt: got %0d want 1", stall_count); end
    issue(1, 10, 10, 1, 11, 1, 0, 0);        // would stall if the flushed lw got into EX
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got %b want 0", stall); end
    tick();
    nop(); tick();
  endtask

  task automatic test_reset_midstream();
    issue(1, 1, 2, 1, 3, 1, 0, 0); tick();   // add $3
    issue(1, 3, 3, 1, 3, 1, 0, 0); tick();   // add $3,$3,$3 now in EX
    issue(1, 3, 1, 1, 4, 1, 0, 0);
    n_cmp++; if (fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL mid_pre_a: got %b want 01", fwd_a_sel); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL mid_a: got %b want 00", fwd_a_sel); end
    n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL mid_b: got %b want 00", fwd_b_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall: got %b want 0", stall); end
    n_cmp++; if (stall_count !== 16'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d want 0", stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    nop();
  endtask

  task automatic test_random();
    logic v, urt, rw, mr, fl;
    logic [AW-1:0] rs, rt, dest;
    v = 0; urt = 0; rw = 0; mr = 0; rs = 0; rt = 0; dest = 0;
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall) begin   // a stalled ID instruction is held in place
        v    = ($urandom_range(0, 9) != 0);
        rs   = AW'($urandom_range(0, 7));
        rt   = AW'($urandom_range(0, 7));
        urt  = 1'($urandom_range(0, 1));
        dest = AW'($urandom_range(0, 7));
        rw   = ($urandom_range(0, 4) != 0);
        mr   = rw && ($urandom_range(0, 1) == 0);
      end
      fl = ($urandom_range(0, 15) == 0);
      issue(v, rs, rt, urt, dest, rw, mr, fl);
      n_cmp++; if (fwd_a_sel !== exp_a) begin n_bad++; $display("FAIL rnd_a[%0d]: got %b want %b", i, fwd_a_sel, exp_a); end
      n_cmp++; if (fwd_b_sel !== exp_b) begin n_bad++; $display("FAIL rnd_b[%0d]: got %b want %b", i, fwd_b_sel, exp_b); end
      n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, exp_stall); end
      n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_count, exp_cnt); end
      n_cmp++; if ({sat_a, sat_b, sat_count} !== {exp_a, exp_b, exp_sat}) begin
        n_bad++; $display("FAIL rnd_sat[%0d]: got %b %b %0d want %b %b %0d", i, sat_a, sat_b, sat_count, exp_a, exp_b, exp_sat);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    // Back-to-back dependent loads: one stall every second cycle.
    for (int i = 0; i < 400 && (i < 10 || model_cnt < (1 << SCW) + 3); i++) begin
      issue(1, 8, 8, 0, 8, 1, 1, 0);         // lw $8,0($8)
      n_cmp++; if (sat_stall !== exp_stall) begin n_bad++; $display("FAIL sat_stall[%0d]: got %b want %b", i, sat_stall, exp_stall); end
      tick();
    end
    nop();
    n_cmp++; if (sat_count !== 6'h3F) begin n_bad++; $display("FAIL sat_hold: got %0d want 63", sat_count); end
    n_cmp++; if (stall_count !== exp_cnt) begin n_bad++; $display("FAIL sat_wide_cnt: got %0d want %0d", stall_count, exp_cnt); end
    tick();
    n_cmp++; if (sat_count !== 6'h3F) begin n_bad++; $display("FAIL sat_hold2: got %0d want 63", sat_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_ex_mem_forward();
    test_wb_forward_priority();
    test_load_use();
    test_zero_and_uses_rt();
    test_flush_vs_stall();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
